// File: rtl/uart_rx_if.sv
// uart_rx_if
// Byte delivery bundle between the serial receiver and its downstream consumer.
//   data      received byte, stable while valid is high
//   valid     a byte is waiting to be taken
//   ack       consumer takes the byte; only meaningful while valid is high
//   frame_err single-cycle pulse: the stop bit was sampled low
//   overrun   single-cycle pulse: a byte arrived while the previous one was still unacknowledged
// The master modport belongs to the receiver and the slave modport to the consumer.
interface uart_rx_if #(
    parameter int DataBits = 8
);
    logic [DataBits-1:0] data;
    logic                valid;
    logic                ack;
    logic                frame_err;
    logic                overrun;

    modport master (
        output data,
        output valid,
        output frame_err,
        output overrun,
        input  ack
    );

    modport slave (
        input  data,
        input  valid,
        input  frame_err,
        input  overrun,
        output ack
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx
// 8N1 (LSB first) serial receiver with an oversampling bit timer.
// Ports:
//   clk_i      system clock
//   reset_i    synchronous active-high reset
//   prescaler  bit-timer divider; one tick every prescaler+1 clocks, captured when a start bit is seen
//   rx         asynchronous serial input, idle high
//   out_if     byte delivery bundle (data/valid/ack handshake, frame_err and overrun pulses)
module uart_rx #(
    parameter int DataBits       = 8,
    parameter int Oversample     = 16,
    parameter int PrescalerWidth = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [PrescalerWidth-1:0] prescaler,
    input  logic                      rx,
    uart_rx_if.master                 out_if
);

    localparam int OsW  = (Oversample > 1) ? $clog2(Oversample) : 1;
    localparam int BitW = (DataBits > 1) ? $clog2(DataBits) : 1;

    localparam logic [OsW-1:0]  OsMid   = OsW'(Oversample / 2 - 1);
    localparam logic [OsW-1:0]  OsLast  = OsW'(Oversample - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(DataBits - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // Synchronizer chain: element 0 is the metastability flop, the last element is rx_s.
    localparam int SyncStages = 2;
    logic [SyncStages-1:0] sync_q;
    logic [SyncStages-1:0] sync_d;
    logic                  rx_s;

    assign sync_d[0] = rx;
    generate
        for (genvar gi = 1; gi < SyncStages; gi++) begin : g_sync
            assign sync_d[gi] = sync_q[gi-1];
        end
    endgenerate
    assign rx_s = sync_q[SyncStages-1];

    state_t                    state_q, state_d;
    logic [PrescalerWidth-1:0] presc_q, presc_d;
    logic [PrescalerWidth-1:0] presc_cnt_q, presc_cnt_d;
    logic [OsW-1:0]            os_cnt_q, os_cnt_d;
    logic [BitW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [DataBits-1:0]       shreg_q, shreg_d;
    logic                      deliver_q, deliver_d;
    logic [DataBits-1:0]       data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q, overrun_d;
    logic                      tick;

    // Every transition out of a timed state happens on a tick, so presc_cnt is
    // already 0 when the next state begins.
    assign tick = (presc_cnt_q == presc_q);

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        presc_cnt_d = '0;
        os_cnt_d    = os_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        deliver_d   = 1'b0;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        // Bit timer only runs while a frame is being timed.
        if (state_q == S_START || state_q == S_DATA || state_q == S_STOP) begin
            presc_cnt_d = tick ? '0 : presc_cnt_q + PrescalerWidth'(1);
            if (tick) begin
                os_cnt_d = (os_cnt_q == OsLast) ? '0 : os_cnt_q + OsW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                os_cnt_d = '0;
                if (!rx_s) begin
                    state_d = S_START;
                    presc_d = prescaler;
                end
            end
            S_START: begin
                if (tick && os_cnt_q == OsMid) begin
                    os_cnt_d  = '0;
                    bit_cnt_d = '0;
                    // A start bit that has vanished by its midpoint is a glitch.
                    state_d   = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick && os_cnt_q == OsLast) begin
                    shreg_d = {rx_s, shreg_q[DataBits-1:1]};
                    if (bit_cnt_q == BitLast) begin
                        state_d  = S_STOP;
                        os_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                    end
                end
            end
            S_STOP: begin
                if (tick && os_cnt_q == OsLast) begin
                    os_cnt_d = '0;
                    if (rx_s) begin
                        deliver_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // Stay here while the line is held low so a break yields one error only.
                os_cnt_d = '0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                os_cnt_d = '0;
            end
        endcase

        // Delivery happens one cycle after the stop-bit sample. An ack in that
        // same cycle frees the output register for the new byte.
        if (deliver_q) begin
            if (!valid_q || out_if.ack) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && out_if.ack) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q      <= '1;
            state_q     <= S_IDLE;
            presc_q     <= '0;
            presc_cnt_q <= '0;
            os_cnt_q    <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            deliver_q   <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
            os_cnt_q    <= os_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            deliver_q   <= deliver_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_if.data      = data_q;
    assign out_if.valid     = valid_q;
    assign out_if.frame_err = frame_err_q;
    assign out_if.overrun   = overrun_q;

endmodule
